// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - multi-lane operand bypass with load-use scoreboard
//
// Purpose: forwards execute-stage source operands from the live writeback
// buses and a DEPTH-cycle bypass history, and stalls issue when an operand
// depends on a load whose data has not returned yet.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush_i       clears pending loads and history valid bits on next edge
//   wb_valid_i    per-lane writeback valid
//   wb_rd_i       per-lane destination register (NUM_WB*RA_W)
//   wb_data_i     per-lane writeback data (NUM_WB*XLEN)
//   rd_valid_i    per-read-port live flag
//   rd_addr_i     per-read-port source register (NUM_RD*RA_W)
//   ld_issue_i    a load enters execute this cycle
//   ld_rd_i       load destination register
//   fwd_o         per-read-port forward select
//   fwd_data_o    per-read-port forwarded operand, 0 when not forwarding
//   stall_o       an operand depends on a pending load
//   pending_o     scoreboard bit vector
module fwd_scoreboard #(
  parameter int NUM_WB   = 3,
  parameter int NUM_RD   = 8,
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 2,
  parameter int LSU_LANE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*RA_W-1:0]   wb_rd_i,
  input  logic [NUM_WB*XLEN-1:0]   wb_data_i,
  input  logic [NUM_RD-1:0]        rd_valid_i,
  input  logic [NUM_RD*RA_W-1:0]   rd_addr_i,
  input  logic                     ld_issue_i,
  input  logic [RA_W-1:0]          ld_rd_i,
  output logic [NUM_RD-1:0]        fwd_o,
  output logic [NUM_RD*XLEN-1:0]   fwd_data_o,
  output logic                     stall_o,
  output logic [(1<<RA_W)-1:0]     pending_o
);

  localparam int NREG = 1 << RA_W;

  logic [NUM_WB-1:0][RA_W-1:0] wb_rd;
  logic [NUM_WB-1:0][XLEN-1:0] wb_data;
  logic [NUM_RD-1:0][RA_W-1:0] rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] fwd_data;

  assign wb_rd      = wb_rd_i;
  assign wb_data    = wb_data_i;
  assign rd_addr    = rd_addr_i;
  assign fwd_data_o = fwd_data;

  // Combined view of all bypass stages; stage 0 is the live writeback bus.
  logic [DEPTH-1:0][NUM_WB-1:0]           stg_valid;
  logic [DEPTH-1:0][NUM_WB-1:0][RA_W-1:0] stg_rd;
  logic [DEPTH-1:0][NUM_WB-1:0][XLEN-1:0] stg_data;

  generate
    if (DEPTH > 1) begin : g_hist
      logic [DEPTH-1:1][NUM_WB-1:0]           h_valid;
      logic [DEPTH-1:1][NUM_WB-1:0][RA_W-1:0] h_rd;
      logic [DEPTH-1:1][NUM_WB-1:0][XLEN-1:0] h_data;

      // Data keeps shifting through a flush; only the valid bits are killed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          h_valid <= '0;
          h_rd    <= '0;
          h_data  <= '0;
        end else begin
          h_valid[1] <= flush_i ? '0 : wb_valid_i;
          h_rd[1]    <= wb_rd;
          h_data[1]  <= wb_data;
          for (int k = 2; k < DEPTH; k++) begin
            h_valid[k] <= flush_i ? '0 : h_valid[k-1];
            h_rd[k]    <= h_rd[k-1];
            h_data[k]  <= h_data[k-1];
          end
        end
      end

      assign stg_valid = {h_valid, wb_valid_i};
      assign stg_rd    = {h_rd, wb_rd};
      assign stg_data  = {h_data, wb_data};
    end else begin : g_nohist
      assign stg_valid = wb_valid_i;
      assign stg_rd    = wb_rd;
      assign stg_data  = wb_data;
    end
  endgenerate

  // Youngest stage first, then lowest lane: the first hit in scan order wins.
  always_comb begin
    fwd_o    = '0;
    fwd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_valid_i[p] && rd_addr[p] != '0) begin
        for (int k = 0; k < DEPTH; k++) begin
          for (int l = 0; l < NUM_WB; l++) begin
            if (!fwd_o[p] && stg_valid[k][l] && stg_rd[k][l] == rd_addr[p]) begin
              fwd_o[p]    = 1'b1;
              fwd_data[p] = stg_data[k][l];
            end
          end
        end
      end
    end
  end

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;

  assign pending_o = pending;

  // A load returning on the LSU lane this very cycle is forwarded, so it
  // does not hold the stall.
  always_comb begin
    stall_o = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_valid_i[p] && rd_addr[p] != '0 && pending[rd_addr[p]] &&
          !(wb_valid_i[LSU_LANE] && wb_rd[LSU_LANE] == rd_addr[p])) begin
        stall_o = 1'b1;
      end
    end
  end

  // Set is applied after clear so a younger load to the same register wins.
  always_comb begin
    pend_nxt = pending;
    if (wb_valid_i[LSU_LANE]) begin
      pend_nxt[wb_rd[LSU_LANE]] = 1'b0;
    end
    if (ld_issue_i && !stall_o && ld_rd_i != '0) begin
      pend_nxt[ld_rd_i] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (flush_i) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed and random bench for fwd_scoreboard
module tb_fwd_scoreboard;

  localparam int NUM_WB   = 3;
  localparam int NUM_RD   = 8;
  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int DEPTH    = 2;
  localparam int LSU_LANE = 2;
  localparam int NREG     = 1 << RA_W;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic [NUM_WB-1:0]      wb_valid;
  logic [NUM_WB*RA_W-1:0] wb_rd;
  logic [NUM_WB*XLEN-1:0] wb_data;
  logic [NUM_RD-1:0]      rd_valid;
  logic [NUM_RD*RA_W-1:0] rd_addr;
  logic                   ld_issue;
  logic [RA_W-1:0]        ld_rd;
  logic [NUM_RD-1:0]      fwd;
  logic [NUM_RD*XLEN-1:0] fwd_data;
  logic                   stall;
  logic [NREG-1:0]        pending;

  fwd_scoreboard #(
    .NUM_WB(NUM_WB), .NUM_RD(NUM_RD), .XLEN(XLEN), .RA_W(RA_W),
    .DEPTH(DEPTH), .LSU_LANE(LSU_LANE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .ld_issue_i(ld_issue), .ld_rd_i(ld_rd),
    .fwd_o(fwd), .fwd_data_o(fwd_data), .stall_o(stall), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          lane;
    int          rd;
    logic [31:0] data;
  } wb_rec_t;

  wb_rec_t         wq[$];
  int              cyc     = 0;
  int              barrier = -1;
  logic [NREG-1:0] pend_m  = '0;
  int              nvec    = 0;
  int              nerr    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    flush    = 1'b0;
    wb_valid = '0;
    wb_rd    = '0;
    wb_data  = '0;
    rd_valid = '0;
    rd_addr  = '0;
    ld_issue = 1'b0;
    ld_rd    = '0;
  endtask

  task automatic set_wb(input int l, input int r, input logic [31:0] d);
    wb_valid[l]              = 1'b1;
    wb_rd[l*RA_W +: RA_W]    = RA_W'(r);
    wb_data[l*XLEN +: XLEN]  = d;
  endtask

  task automatic set_rd(input int p, input int r);
    rd_valid[p]              = 1'b1;
    rd_addr[p*RA_W +: RA_W]  = RA_W'(r);
  endtask

  task automatic ld(input int r);
    ld_issue = 1'b1;
    ld_rd    = RA_W'(r);
  endtask

  // One clock: model the current inputs, compare at negedge, advance at posedge.
  task automatic step(input string tag, input int xp = -1, input logic xf = 1'b0,
                      input logic [31:0] xd = 32'h0, input int xs = -1);
    logic [NUM_RD-1:0]      ef;
    logic [NUM_RD*XLEN-1:0] ed;
    logic                   es;
    int                     a;
    int                     best;
    int                     bkey;
    int                     key;
    wb_rec_t                rec;
    if (!rst_n) begin
      pend_m  = '0;
      barrier = cyc - 1;
    end
    for (int l = 0; l < NUM_WB; l++) begin
      if (wb_valid[l]) begin
        rec.cyc  = cyc;
        rec.lane = l;
        rec.rd   = int'(wb_rd[l*RA_W +: RA_W]);
        rec.data = wb_data[l*XLEN +: XLEN];
        wq.push_back(rec);
      end
    end
    ef = '0;
    ed = '0;
    es = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = int'(rd_addr[p*RA_W +: RA_W]);
      if (rd_valid[p] && a != 0) begin
        best = -1;
        bkey = 1 << 30;
        foreach (wq[i]) begin
          if (wq[i].cyc > barrier && cyc - wq[i].cyc < DEPTH && wq[i].rd == a) begin
            key = (cyc - wq[i].cyc) * NUM_WB + wq[i].lane;
            if (key < bkey) begin
              bkey = key;
              best = i;
            end
          end
        end
        if (best >= 0) begin
          ef[p]                = 1'b1;
          ed[p*XLEN +: XLEN]   = wq[best].data;
        end
        if (pend_m[a] && !(wb_valid[LSU_LANE] &&
                           int'(wb_rd[LSU_LANE*RA_W +: RA_W]) == a)) begin
          es = 1'b1;
        end
      end
    end
    @(negedge clk);
    for (int p = 0; p < NUM_RD; p++) begin
      chk({tag, "_fwd"}, 64'(fwd[p]), 64'(ef[p]));
      chk({tag, "_data"}, 64'(fwd_data[p*XLEN +: XLEN]), 64'(ed[p*XLEN +: XLEN]));
    end
    chk({tag, "_stall"}, 64'(stall), 64'(es));
    chk({tag, "_pending"}, 64'(pending), 64'(pend_m));
    if (xp >= 0) begin
      chk({tag, "_xfwd"}, 64'(fwd[xp]), 64'(xf));
      chk({tag, "_xdata"}, 64'(fwd_data[xp*XLEN +: XLEN]), 64'(xd));
    end
    if (xs >= 0) chk({tag, "_xstall"}, 64'(stall), 64'(xs));
    @(posedge clk);
    if (!rst_n || flush) begin
      pend_m  = '0;
      barrier = cyc;
    end else begin
      if (wb_valid[LSU_LANE]) pend_m[wb_rd[LSU_LANE*RA_W +: RA_W]] = 1'b0;
      if (ld_issue && !es && ld_rd != '0) pend_m[ld_rd] = 1'b1;
    end
    cyc++;
    while (wq.size() > 0 && wq[0].cyc <= cyc - DEPTH) void'(wq.pop_front());
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    step("idle");

    // Same-cycle bypass, then register 0 never forwards.
    idle(); set_wb(1, 5, 32'hDEADBEEF); set_rd(0, 5);
    step("byp", 0, 1'b1, 32'hDEADBEEF);
    idle(); set_wb(1, 0, 32'hDEADBEEF); set_rd(0, 0);
    step("byp_r0", 0, 1'b0, 32'h0);
    idle(); step("gap0"); step("gap1");

    // Stage and lane priority, then age-out.
    idle(); set_wb(0, 7, 32'h11); set_wb(2, 7, 32'h22); set_rd(3, 7);
    step("pri_t", 3, 1'b1, 32'h11);
    idle(); set_wb(1, 7, 32'h33); set_rd(3, 7);
    step("pri_t1", 3, 1'b1, 32'h33);
    idle(); set_rd(3, 7);
    step("pri_t2", 3, 1'b1, 32'h33);
    step("pri_t3", 3, 1'b0, 32'h0);

    // Load-use stall released by same-cycle return.
    idle(); ld(9); step("lu_t");
    idle(); set_rd(2, 9); step("lu_t1", -1, 1'b0, 32'h0, 1);
    step("lu_t2", -1, 1'b0, 32'h0, 1);
    set_wb(2, 9, 32'h1234);
    step("lu_t3", 2, 1'b1, 32'h1234, 0);
    idle(); step("lu_t4");

    // Return and new load to the same register in one cycle.
    idle(); ld(4); step("col0");
    idle(); set_wb(2, 4, 32'h55); ld(4); step("col1");
    idle(); step("col2");

    // Load issue ignored while stalled.
    idle(); set_rd(0, 4); ld(6); step("gate", -1, 1'b0, 32'h0, 1);
    idle(); step("gate1");
    set_wb(2, 4, 32'h66); step("gate_ret");

    // Flush with pending loads and full history.
    idle(); ld(3); step("fl0");
    idle(); ld(8); set_wb(0, 10, 32'hA0); set_wb(1, 11, 32'hB0); step("fl1");
    idle(); set_wb(0, 12, 32'hC0); flush = 1'b1; set_rd(0, 12);
    step("fl2", 0, 1'b1, 32'hC0);
    idle(); set_rd(0, 12); set_rd(1, 3); set_rd(2, 8);
    step("fl3", 0, 1'b0, 32'h0, 0);

    // Asynchronous reset mid-stall.
    idle(); ld(13); step("rs0");
    idle(); set_rd(1, 13); step("rs1", -1, 1'b0, 32'h0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_stall", 64'(stall), 64'(0));
    step("rs2", -1, 1'b0, 32'h0, 0);
    rst_n = 1'b1;
    idle(); step("rs3");

    // Randomised traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int l = 0; l < NUM_WB; l++)
        if ($urandom_range(0, 2) == 0) set_wb(l, $urandom_range(0, 7), $urandom);
      for (int p = 0; p < NUM_RD; p++)
        if ($urandom_range(0, 1) == 0) set_rd(p, $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ld($urandom_range(0, 7));
      flush = ($urandom_range(0, 29) == 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
